// File: rtl/jsq4_2_pulse.sv
// Single-shot pulse generator. An accepted trigger produces an optional idle
// gap of DELAY cycles followed by WIDTH high cycles on dout. Triggers arriving
// while a sequence is in progress are dropped.
module jsq4_2_pulse #(
    parameter int unsigned DELAY = 0,
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic dout
);

    // Counter value on the last cycle of a sequence (L-1).
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY + WIDTH - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dout_q;
    logic             in_window;

    // Upper bound of the window is implied: cnt never exceeds LAST while busy.
    generate
        if (DELAY == 0) begin : g_no_delay
            assign in_window = 1'b1;
        end else begin : g_delay
            localparam logic [CNT_W-1:0] FIRST = CNT_W'(DELAY);
            assign in_window = (cnt_q >= FIRST);
        end
    endgenerate

    // Sequence state, counter and registered pulse output. rst_n is active-high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            // dout reflects the state held during the cycle just ended, so the
            // first high cycle follows the accepting edge by DELAY+1 edges.
            dout_q <= (state_q == StBusy) && in_window;
            case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StBusy;
                        cnt_q   <= '0;
                    end
                end
                StBusy: begin
                    // en is deliberately not looked at here: no retrigger.
                    if (cnt_q == LAST) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_jsq4_2_pulse.sv
// Bench for jsq4_2_pulse: a default-parameter instance (a) and a DELAY=3,
// WIDTH=2 instance (b) share clock and reset. Each stimulus cycle pushes the
// hand-computed dout values for both instances; a monitor pops and compares.
module tb_jsq4_2_pulse;

    logic clk;
    logic rst_n;
    logic en_a;
    logic en_b;
    logic dout_a;
    logic dout_b;

    typedef struct {
        logic  xa;
        logic  xb;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    jsq4_2_pulse u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_a),
        .dout  (dout_a)
    );

    jsq4_2_pulse #(
        .DELAY (3),
        .WIDTH (2),
        .CNT_W (4)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_b),
        .dout  (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for one edge, then queue the dout values required after it.
    task automatic cyc(input logic ea, input logic eb, input logic r,
                       input logic xa, input logic xb, input string tag);
        exp_t e;
        en_a  = ea;
        en_b  = eb;
        rst_n = r;
        @(posedge clk);
        #1;
        e.xa  = xa;
        e.xb  = xb;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One default-width pulse on instance a plus a quiet tail.
    task automatic pulse_a(input string tag);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_accept"});
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_high"});
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_tail"});
    endtask

    // Monitor: compare one queued expectation per cycle, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (dout_a !== e.xa) begin
                    n_miss++;
                    $display("FAIL %s dut_a: dout=%b required %b at %0t", e.tag, dout_a, e.xa,
                             $time);
                end
                n_vec++;
                if (dout_b !== e.xb) begin
                    n_miss++;
                    $display("FAIL %s dut_b: dout=%b required %b at %0t", e.tag, dout_b, e.xb,
                             $time);
                end
            end
        end
    end

    // Hard stop in case something stalls the stimulus.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b1;

        // 1: reset held, then released with no trigger.
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset_hold");
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_release");

        // 2 and 3: single trigger, then the same after 15 idle cycles.
        pulse_a("single");
        repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_gap");
        pulse_a("repeat");

        // 4: triggers at k+5 and k+10 land while busy and are ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "busy_accept");
        for (int i = 1; i <= 10; i++) begin
            cyc((i == 5 || i == 10), 1'b0, 1'b0, 1'b1, 1'b0, "busy_high");
        end
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "busy_no_retrigger");

        // 5: en held 40 cycles -> accept every 11 edges, 10 high then 1 low.
        for (int i = 0; i <= 44; i++) begin
            cyc((i < 40), 1'b0, 1'b0, (i % 11 != 0), 1'b0, "continuous");
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "continuous_end");

        // 6a: reset sampled at k+5 kills the pulse; then a fresh full pulse.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_accept");
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "midrst_high");
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "midrst_reset");
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_released");
        pulse_a("after_reset");

        // Reset and en on the same edge: trigger lost.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rst_en_same_edge");
        repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_en_lost");

        // 6b: DELAY=3, WIDTH=2 -> high only at k+4 and k+5.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "delay_accept");
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, (i == 4 || i == 5), "delay_single");
        end

        // DELAY=3, WIDTH=2 with en held: sequences repeat every L+1 = 6 edges.
        for (int i = 0; i <= 11; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, (i % 6 == 4 || i % 6 == 5), "delay_continuous");
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "delay_end");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
